// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared constants for the CPU memory arbiter: response-owner IDs and the
// width of the flattened sram-like request bundle {wr, size, addr, wstrb, wdata}.
package cpu_mem_arbiter_pkg;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    localparam int SRAM_LIKE_REQ_WD = 71;

    typedef logic [SRAM_LIKE_REQ_WD-1:0] sram_req_t;

    function automatic sram_req_t pack_req(
        input logic        wr,
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [3:0]  wstrb,
        input logic [31:0] wdata
    );
        return {wr, size, addr, wstrb, wdata};
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_id_fifo.sv
// Response-ownership FIFO: one bit per accepted request (0=inst, 1=data),
// popped in order as responses return. A push into a full FIFO is dropped.
module mem_arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok_s, pop_ok_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the CPU's inst and data sram-like ports onto one memory port,
// returning in-order responses to their owner and promoting a starved inst fetch.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        resp_err
);

    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

    logic          full_s, empty_s, head_s;
    logic          sel_data_s, sel_inst_s, req_any_s, hs_s, inst_hs_s, inst_denied_s;
    logic          rsp_s;
    sram_req_t     inst_bus_s, data_bus_s, mem_bus_s;
    logic [SW-1:0] starve_q, starve_d;
    logic          promote_q, promote_d;
    logic          resp_err_q, resp_err_d;

    // Data wins by default (older in the pipeline) unless inst has been promoted.
    assign sel_data_s    = data_req & ~(promote_q & inst_req);
    assign sel_inst_s    = inst_req & ~sel_data_s;
    assign req_any_s     = (inst_req | data_req) & ~full_s & ~reset;
    assign hs_s          = req_any_s & mem_addr_ok;
    assign inst_hs_s     = hs_s & sel_inst_s;
    assign inst_denied_s = inst_req & ~inst_hs_s;
    assign rsp_s         = mem_data_ok & ~empty_s & ~reset;

    assign inst_bus_s = pack_req(inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata);
    assign data_bus_s = pack_req(data_wr, data_size, data_addr, data_wstrb, data_wdata);
    assign mem_bus_s  = reset ? '0 : ((sel_data_s & req_any_s) ? data_bus_s : inst_bus_s);

    assign mem_req = req_any_s;
    assign {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} = mem_bus_s;

    assign data_addr_ok = hs_s & sel_data_s;
    assign inst_addr_ok = inst_hs_s;
    assign inst_data_ok = rsp_s & (head_s == ARB_ID_INST);
    assign data_data_ok = rsp_s & (head_s == ARB_ID_DATA);
    assign inst_rdata   = reset ? '0 : mem_rdata;
    assign data_rdata   = reset ? '0 : mem_rdata;
    assign resp_err     = resp_err_q;

    mem_arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (hs_s),
        .din_i   (sel_data_s ? ARB_ID_DATA : ARB_ID_INST),
        .pop_i   (mem_data_ok),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Starvation counter saturates so a long full stall cannot wrap it.
    always_comb begin
        starve_d   = starve_q;
        promote_d  = promote_q;
        resp_err_d = resp_err_q | (mem_data_ok & empty_s);
        if (inst_denied_s) begin
            if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = '0;
        end
        if (inst_hs_s) begin
            promote_d = 1'b0;
        end else if (inst_denied_s && (starve_q == STARVE_MAX)) begin
            promote_d = 1'b1;
        end else begin
            promote_d = promote_q;
        end
    end

    // Starvation and error state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q   <= '0;
            promote_q  <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            promote_q  <= promote_d;
            resp_err_q <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: request-side checks are inline, response
// ownership and data are checked by a negedge monitor against a scoreboard queue.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];
    logic mq[$];

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0;
        inst_wstrb = 4'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
        data_wstrb = 4'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic respond(input logic is_data, input logic [31:0] rd);
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        sb.push_back('{is_data: is_data, rdata: rd});
    endtask

    // Monitor: every response the DUT presents must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && (inst_data_ok || data_data_ok)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got inst_ok=%b data_ok=%b expected none",
                         inst_data_ok, data_data_ok);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (inst_data_ok !== !e.is_data || data_data_ok !== e.is_data ||
                    (e.is_data ? data_rdata : inst_rdata) !== e.rdata) begin
                    bad++;
                    $display("FAIL resp: got inst_ok=%b data_ok=%b irdata=%h drdata=%h expected owner_data=%b rdata=%h",
                             inst_data_ok, data_data_ok, inst_rdata, data_rdata, e.is_data, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        check("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check("rst_rdata", inst_rdata | data_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        tick();
        idle();
        reset = 1'b0;
        tick();

        // Simultaneous requests: data wins.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_addr = 32'h8000_1000; data_wr = 1'b1;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check("prio_data_ok", {31'd0, data_addr_ok}, 32'd1);
        check("prio_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
        check("prio_addr", mem_addr, 32'h8000_1000);
        check("prio_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("prio_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        idle();
        respond(1'b1, 32'hAAAA_5555);
        tick();
        idle();

        // In-order ownership: inst then data.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1;
        @(negedge clk);
        check("ord_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
        check("ord_inst_addr", mem_addr, 32'hBFC0_0000);
        tick();
        idle();
        data_req = 1'b1; data_addr = 32'h8000_1000; mem_addr_ok = 1'b1;
        @(negedge clk);
        check("ord_data_ok", {31'd0, data_addr_ok}, 32'd1);
        tick();
        idle();
        respond(1'b0, 32'h1111_1111);
        tick();
        idle();
        respond(1'b1, 32'h2222_2222);
        tick();
        idle();

        // Full: two outstanding blocks the third, also on the pop cycle.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0010; mem_addr_ok = 1'b1;
        tick();
        idle();
        data_req = 1'b1; data_addr = 32'h8000_2000; mem_addr_ok = 1'b1;
        tick();
        idle();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0020; mem_addr_ok = 1'b1;
        @(negedge clk);
        check("full_mem_req", {31'd0, mem_req}, 32'd0);
        check("full_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        respond(1'b0, 32'h3333_3333);
        @(negedge clk);
        check("full_pop_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("after_pop_mem_req", {31'd0, mem_req}, 32'd1);
        check("after_pop_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
        check("after_pop_addr", mem_addr, 32'hBFC0_0020);
        tick();
        idle();
        respond(1'b1, 32'h4444_4444);
        tick();
        idle();
        respond(1'b0, 32'h5555_5555);
        tick();
        idle();

        // Starvation: data always requesting; inst promoted on cycle STARVE_LIMIT.
        for (int k = 0; k <= 10; k++) begin
            logic exp_inst;
            exp_inst = (k == 8);
            inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
            data_req = 1'b1; data_addr = 32'h8000_3000;
            mem_addr_ok = 1'b1;
            if (k >= 1) begin
                respond(mq.pop_front(), 32'h5000_0000 + k);
            end
            mq.push_back(!exp_inst);
            @(negedge clk);
            check($sformatf("starve_inst_ok_%0d", k), {31'd0, inst_addr_ok}, {31'd0, exp_inst});
            check($sformatf("starve_data_ok_%0d", k), {31'd0, data_addr_ok}, {31'd0, !exp_inst});
            tick();
        end
        idle();
        respond(mq.pop_front(), 32'h5000_00FF);
        tick();
        idle();

        // Spurious response sets a sticky error.
        mem_data_ok = 1'b1; mem_rdata = 32'h9999_9999;
        tick();
        idle();
        @(negedge clk);
        check("err_set", {31'd0, resp_err}, 32'd1);
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0200; mem_addr_ok = 1'b1;
        tick();
        idle();
        respond(1'b0, 32'h6060_6060);
        tick();
        idle();
        @(negedge clk);
        check("err_sticky", {31'd0, resp_err}, 32'd1);
        tick();

        // Asynchronous reset with two outstanding.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0300; mem_addr_ok = 1'b1;
        tick();
        idle();
        data_req = 1'b1; data_addr = 32'h8000_4000; mem_addr_ok = 1'b1;
        tick();
        inst_req = 1'b1; data_req = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
        #2;
        reset = 1'b1;
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        check("arst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check("arst_rdata", inst_rdata | data_rdata, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_err", {31'd0, resp_err}, 32'd0);
        tick();
        idle();
        reset = 1'b0;
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0400; mem_addr_ok = 1'b1;
        @(negedge clk);
        check("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
        check("post_rst_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        idle();
        respond(1'b0, 32'h6666_6666);
        tick();
        idle();
        tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
